event_fifo: RTL

Parametrised synchronous event FIFO, the successor to the team's basic push/pop FIFO. It uses valid/ready handshakes on both sides with first-word-fall-through output and a compile-time overflow policy (drop-new or drop-oldest). It also provides programmable almost-full/almost-empty flags and optional occupancy/drop statistics. It buffers timestamped monitor events between event capture and the readout/arbitration stage.

---
 rtl/event_fifo.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/event_fifo.sv
// event_fifo: parametrised first-word-fall-through event FIFO with valid/ready handshakes,
// compile-time overflow policy and programmable almost-full/empty flags.
// Define EVENT_FIFO_STATS_EN to build the drop_count/high_water statistics registers.
module event_fifo #(
  parameter int  W          = 72,
  parameter int  DEPTH      = 16,
  parameter int  OVF_POLICY = 0,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  input  logic [CW-1:0] afull_thresh,
  input  logic [CW-1:0] aempty_thresh,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          drop_pulse,
  input  logic          clear_stats,
  output logic [15:0]   drop_count,
  output logic [CW-1:0] high_water
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          drop_pulse_q;
  logic          full, push, pop, overwrite, drop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    full      = (count_q == FULL_CNT);
    pop       = (count_q != '0) && out_ready;
    in_ready  = 1'b0;
    push      = 1'b0;
    overwrite = 1'b0;
    drop      = 1'b0;
    if (OVF_POLICY == 0) begin
      in_ready = !full && !rst;
      push     = in_valid && in_ready;
      drop     = in_valid && !in_ready && !rst;
    end else begin
      in_ready  = !rst;
      push      = in_valid && !rst;
      overwrite = push && full && !pop;
      drop      = overwrite;
    end

    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    // Overwrite-oldest advances the head past the entry being replaced.
    rptr_d = (pop || overwrite) ? ptr_inc(rptr_q) : rptr_q;

    count_d = count_q;
    if (push && !pop && !overwrite) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      count_q      <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      drop_pulse_q <= drop;
    end
  end

  // NOTE: storage is deliberately not reset; out_valid gates every read, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_data;
    end
  end

  assign out_valid    = (count_q != '0);
  assign out_data     = mem_q[rptr_q];
  assign count        = count_q;
  assign almost_full  = (count_q >= afull_thresh);
  assign almost_empty = (count_q <= aempty_thresh);
  assign drop_pulse   = drop_pulse_q;

`ifdef EVENT_FIFO_STATS_EN
  logic [15:0]   drop_count_q, drop_count_d;
  logic [CW-1:0] high_water_q, high_water_d;

  // A clear in the same cycle as a drop wins outright.
  always_comb begin
    drop_count_d = drop_count_q;
    high_water_d = high_water_q;
    if (clear_stats) begin
      drop_count_d = '0;
      high_water_d = count_q;
    end else begin
      if (drop && (drop_count_q != 16'hFFFF)) begin
        drop_count_d = drop_count_q + 1'b1;
      end
      if (count_d > high_water_q) begin
        high_water_d = count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
      high_water_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      high_water_q <= high_water_d;
    end
  end

  assign drop_count = drop_count_q;
  assign high_water = high_water_q;
`else
  logic unused_clear_stats;
  assign unused_clear_stats = clear_stats;
  assign drop_count         = '0;
  assign high_water         = '0;
`endif

endmodule
